ll_keyrx: RTL and testbench

//  Receive end of the keysync strobe interface. Consumes the 5-bit encoded keycode and its delayed strobe keyclk.

---
 rtl/ll_keyrx.sv | 92 +++++++++
 tb/tb_ll_keyrx.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ll_keyrx.sv
// ll_keyrx: keysync receiver, one event per press into thrust/sel/event FIFO; LL_KEYRX_LOCKOUT_EN adds post-press lockout
module ll_keyrx #(
  parameter int DEPTH = 4,
  parameter int LOCK_CYCLES = 10,
  parameter logic [15:0] THRUST_INIT = 16'h0005
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [4:0]               keycode,
  input  logic                     keyclk,
  output logic [15:0]              thrust,
  output logic [1:0]               sel,
  output logic                     ev_valid,
  output logic [4:0]               ev_code,
  input  logic                     ev_rd,
  output logic [$clog2(DEPTH):0]   ev_count,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef LL_KEYRX_LOCKOUT_EN
  localparam int LW = $clog2(LOCK_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, LOCK, WAIT_REL} state_t;
  logic [LW-1:0] cnt, ncnt;
`else
  typedef enum logic {IDLE, WAIT_REL} state_t;
`endif
  state_t state, nstate;
  logic k1, k2;
  logic [4:0] kc1;
  logic rise, accept, is_dig, is_sel, push, pop, full, wr_en;
  logic [AW-1:0] rd, wr;
  logic [CW-1:0] count;
  logic [4:0] mem [DEPTH];
  assign rise = k1 & ~k2;
  assign accept = (state == IDLE) & rise;
  assign is_dig = kc1 < 5'd10;
  assign is_sel = kc1[4:2] == 3'b100;
  assign push = accept & (is_dig | is_sel);
  assign pop = ev_rd & (count != '0);
  assign full = count == CW'(DEPTH);
  // a full FIFO still takes the push when the head leaves in the same cycle
  assign wr_en = push & (~full | pop);
  assign ev_valid = count != '0;
  assign ev_count = count;
  assign ev_code = mem[rd];
  always_comb begin
`ifdef LL_KEYRX_LOCKOUT_EN
    nstate = state == IDLE ? (rise ? LOCK : IDLE) :
             state == LOCK ? (cnt == '0 ? WAIT_REL : LOCK) :
             (k1 ? WAIT_REL : IDLE);
    ncnt = state == IDLE ? LW'(LOCK_CYCLES - 1) : cnt - LW'(state == LOCK && cnt != '0);
`else
    nstate = state == IDLE ? (rise ? WAIT_REL : IDLE) : (k1 ? WAIT_REL : IDLE);
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      k1 <= 1'b0;
      k2 <= 1'b0;
      kc1 <= '0;
      state <= IDLE;
`ifdef LL_KEYRX_LOCKOUT_EN
      cnt <= '0;
`endif
      thrust <= THRUST_INIT;
      sel <= '0;
      rd <= '0;
      wr <= '0;
      count <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      k1 <= keyclk;
      k2 <= k1;
      kc1 <= keycode;
      state <= nstate;
`ifdef LL_KEYRX_LOCKOUT_EN
      cnt <= ncnt;
`endif
      if (accept && is_dig) thrust <= {12'h000, kc1[3:0]};
      if (accept && is_sel) sel <= kc1[1:0];
      if (wr_en) begin
        mem[wr] <= kc1;
        wr <= wr + 1'b1;
      end
      if (pop) rd <= rd + 1'b1;
      if (push && !wr_en) overflow <= 1'b1;
      count <= count + CW'(wr_en) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_ll_keyrx.sv
// tb_ll_keyrx: directed bench with an event-level model of ll_keyrx compared every cycle
module tb_ll_keyrx;
  localparam int DEPTH = 4;
  localparam int LOCK = 10;
`ifdef LL_KEYRX_LOCKOUT_EN
  localparam int HOLD_OFF = LOCK + 1;
`else
  localparam int HOLD_OFF = 1;
`endif
  logic clk = 0, rst = 1, keyclk = 0, ev_rd = 0;
  logic [4:0] keycode = '0;
  logic [15:0] thrust;
  logic [1:0] sel;
  logic ev_valid, overflow;
  logic [4:0] ev_code;
  logic [2:0] ev_count;
  int total = 0, bad = 0;
  ll_keyrx #(.DEPTH(DEPTH), .LOCK_CYCLES(LOCK), .THRUST_INIT(16'h0005)) dut (
    .clk(clk), .rst(rst), .keycode(keycode), .keyclk(keyclk), .thrust(thrust), .sel(sel),
    .ev_valid(ev_valid), .ev_code(ev_code), .ev_rd(ev_rd), .ev_count(ev_count), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Event model: a press is taken on a fresh keyclk high when no earlier press is pending
  // release; release only counts once HOLD_OFF edges have passed since that press.
  logic [15:0] m_thrust;
  logic [1:0] m_sel;
  logic m_ovf, m_started = 0, m_prev, m_pend, m_any, m_low, m_popped;
  logic [4:0] m_pcode;
  logic [4:0] q[$];
  int m_edge = 0, m_wr_start = 0;
  always @(posedge clk) begin
    m_edge++;
    if (rst) begin
      m_thrust = 16'h0005; m_sel = 0; m_ovf = 0; q.delete();
      m_prev = 0; m_pend = 0; m_any = 0; m_low = 0; m_started = 1;
    end else begin
      m_popped = ev_rd && q.size() != 0;
      if (m_popped) void'(q.pop_front());
      if (m_pend) begin
        if (m_pcode < 10) m_thrust = {12'h000, m_pcode[3:0]};
        else m_sel = m_pcode[1:0];
        if (q.size() < DEPTH) q.push_back(m_pcode);
        else m_ovf = 1;
      end
      m_pend = 0;
      if (keyclk && !m_prev && (!m_any || m_low)) begin
        m_any = 1; m_low = 0; m_wr_start = m_edge + HOLD_OFF;
        m_pend = keycode < 10 || (keycode >= 16 && keycode <= 19);
        m_pcode = keycode;
      end else if (m_any && m_edge >= m_wr_start && !keyclk) m_low = 1;
      m_prev = keyclk;
    end
  end
  always @(negedge clk) if (m_started) begin
    chk("thrust", thrust, m_thrust);
    chk("sel", sel, m_sel);
    chk("ev_valid", ev_valid, q.size() != 0);
    chk("ev_count", ev_count, q.size());
    chk("overflow", overflow, m_ovf);
    if (q.size() != 0) chk("ev_code", ev_code, q[0]);
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic press(input logic [4:0] c, input int hold, input int gap);
    keycode = c; keyclk = 1; cyc(hold);
    keyclk = 0; cyc(gap);
  endtask
  task automatic both(input string nm, input logic [31:0] d, input logic [31:0] m, input logic [31:0] e);
    chk(nm, d, e);
    chk({nm, "_model"}, m, e);
  endtask
  task automatic pop_expect(input logic [4:0] e);
    both("head_valid", ev_valid, q.size() != 0, 1);
    both("head_code", ev_code, q.size() != 0 ? q[0] : 5'h1f, e);
    ev_rd = 1; cyc(1); ev_rd = 0;
  endtask
  task automatic do_reset();
    rst = 1; cyc(1); rst = 0; cyc(1);
  endtask
  task automatic reset_vals(input string nm);
    both({nm, "_thrust"}, thrust, m_thrust, 16'h0005);
    both({nm, "_sel"}, sel, m_sel, 0);
    both({nm, "_count"}, ev_count, q.size(), 0);
    chk({nm, "_valid"}, ev_valid, 0);
    chk({nm, "_code"}, ev_code, 0);
    both({nm, "_ovf"}, overflow, m_ovf, 0);
  endtask
  initial begin
    cyc(2);
    reset_vals("rst");
    rst = 0; cyc(2);
    press(7, 30, 15);
    both("t2_thrust", thrust, m_thrust, 16'h0007);
    both("t2_count", ev_count, q.size(), 1);
    pop_expect(7);
    chk("t2_empty", ev_valid, 0);
    do_reset();
    press(18, 3, 3);
    press(3, 3, 16);
    both("t3_sel", sel, m_sel, 2);
`ifdef LL_KEYRX_LOCKOUT_EN
    both("t3_thrust", thrust, m_thrust, 16'h0005);
    both("t3_count", ev_count, q.size(), 1);
    pop_expect(18);
`else
    both("t3_thrust", thrust, m_thrust, 16'h0003);
    both("t3_count", ev_count, q.size(), 2);
    pop_expect(18);
    pop_expect(3);
`endif
    chk("t3_empty", ev_valid, 0);
    for (int c = 1; c <= 5; c++) press(5'(c), 2, 14);
    both("t4_count", ev_count, q.size(), 4);
    both("t4_ovf", overflow, m_ovf, 1);
    for (int c = 1; c <= 4; c++) pop_expect(5'(c));
    chk("t4_empty", ev_valid, 0);
    chk("t4_ovf_sticky", overflow, 1);
    do_reset();
    for (int c = 1; c <= 4; c++) press(5'(c), 2, 14);
    both("t5_full", ev_count, q.size(), 4);
    keycode = 9; keyclk = 1; cyc(1);
    ev_rd = 1; cyc(1); ev_rd = 0;
    both("t5_count", ev_count, q.size(), 4);
    both("t5_ovf", overflow, m_ovf, 0);
    keyclk = 0; cyc(14);
    both("t5_thrust", thrust, m_thrust, 16'h0009);
    pop_expect(2); pop_expect(3); pop_expect(4); pop_expect(9);
    chk("t5_empty", ev_valid, 0);
    press(12, 2, 14);
    both("t6_thrust", thrust, m_thrust, 16'h0009);
    both("t6_sel", sel, m_sel, 0);
    both("t6_count", ev_count, q.size(), 0);
    keycode = 6; keyclk = 1; cyc(4);
    both("t6_pre", thrust, m_thrust, 16'h0006);
    rst = 1; cyc(1);
    reset_vals("t6_rst");
    rst = 0; cyc(3);
    both("t6_thrust2", thrust, m_thrust, 16'h0006);
    both("t6_count2", ev_count, q.size(), 1);
    keyclk = 0; cyc(15);
    both("t6_count3", ev_count, q.size(), 1);
    both("t6_code", ev_code, q.size() != 0 ? q[0] : 5'h1f, 6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
